// File: rtl/seven_segment_scan_display_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment driver.
// Glyphs are active-low in bit order g f e d c b a.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    localparam logic [6:0] GLYPH_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_ERROR = 7'b0001110;

    // Non-decimal nibbles render as blank rather than garbage.
    function automatic logic [6:0] bcd_to_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        g = GLYPH_BLANK;
        for (int d = 0; d < 10; d++) begin
            if (nibble == 4'(d)) g = GLYPH_DIGIT[d];
        end
        return g;
    endfunction

endpackage

// File: rtl/seven_segment_scan_display_if.sv
// Request/status and display-pin bundle between the datapath, the driver and the board.
interface seven_segment_scan_display_if #(
    parameter int DW       = 8,
    parameter int DIGITS   = 4,
    parameter int SEGMENTS = 7
);
    logic                start;
    logic                signed_mode;
    logic [DW-1:0]       number;
    logic                error;
    logic                busy;
    logic                done;
    logic [DIGITS-1:0]   anodes;
    logic [SEGMENTS-1:0] segments;

    modport master (
        output start, signed_mode, number, error,
        input  busy, done, anodes, segments
    );

    modport slave (
        input  start, signed_mode, number, error,
        output busy, done, anodes, segments
    );
endinterface

// File: rtl/seven_segment_scan_display_bin2bcd.sv
// Serial double-dabble converter: one shift per cycle after start, DW shifts in total.
// done is high in the cycle whose closing edge performs the final shift.
module bin2bcd_serial #(
    parameter int DW         = 8,
    parameter int BCD_DIGITS = (DW + 2) / 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DW-1:0]           mag,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0]           shreg;
    logic [CW-1:0]           remaining;
    logic [4*BCD_DIGITS-1:0] adjusted;

    always_comb begin
        adjusted = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = (remaining == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bcd       <= '0;
            remaining <= '0;
        end else if (start) begin
            shreg     <= mag;
            bcd       <= '0;
            remaining <= CW'(DW);
        end else if (remaining != '0) begin
            bcd       <= {adjusted[4*BCD_DIGITS-2:0], shreg[DW-1]};
            shreg     <= shreg << 1;
            remaining <= remaining - 1'b1;
        end
    end
endmodule

// File: rtl/seven_segment_scan_display.sv
// Converts a binary value to decimal glyphs with sign, blanking and error handling,
// then time-multiplexes the digits onto common-anode pins.
module seven_segment_scan_display
    import seven_seg_pkg::*;
#(
    parameter int DW             = 8,
    parameter int DIGITS         = 4,
    parameter int SEGMENTS       = 7,
    parameter int REFRESH_CYCLES = 50000
) (
    input logic clk,
    input logic rst,
    seven_segment_scan_display_if.slave bus
);
    localparam int BCD_DIGITS = (DW + 2) / 3;
    localparam int PAD_DIGITS = (DIGITS > BCD_DIGITS) ? DIGITS : BCD_DIGITS;
    localparam int IDX_W      = $clog2(DIGITS);
    localparam int REF_W      = $clog2(REFRESH_CYCLES);

    state_t                  state, next_state;
    logic                    conv_start, conv_done, commit;
    logic                    neg_in, neg_q, err_q, overflow;
    logic [DW-1:0]           mag;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [4*PAD_DIGITS-1:0] bcd_pad;

    logic [3:0]              disp_digit [DIGITS];
    logic                    disp_neg, disp_err;
    logic [REF_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        scan_idx, msd_idx;
    logic [6:0]              glyph;

    // Most-negative input negates to itself, which is still the right unsigned magnitude.
    assign neg_in  = bus.signed_mode & bus.number[DW-1];
    assign mag     = neg_in ? -bus.number : bus.number;
    assign bcd_pad = (4*PAD_DIGITS)'(bcd);

    bin2bcd_serial #(.DW(DW), .BCD_DIGITS(BCD_DIGITS)) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .mag   (mag),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        conv_start = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = CONVERT;
                    conv_start = 1'b1;
                end
            end
            CONVERT: begin
                if (conv_done) next_state = COMMIT;
            end
            COMMIT: begin
                next_state = IDLE;
                commit     = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            err_q <= 1'b0;
        end else if (conv_start) begin
            neg_q <= neg_in;
            err_q <= bus.error;
        end
    end

    // A negative result gives up the top display position to the minus sign.
    always_comb begin
        overflow = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if ((i >= DIGITS || (neg_q && i == DIGITS - 1)) && bcd_pad[4*i +: 4] != 4'd0)
                overflow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) disp_digit[i] <= 4'd0;
            disp_neg <= 1'b0;
            disp_err <= 1'b0;
        end else if (commit) begin
            for (int i = 0; i < DIGITS; i++) disp_digit[i] <= bcd_pad[4*i +: 4];
            disp_neg <= neg_q;
            disp_err <= err_q | overflow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_digit[i] != 4'd0) msd_idx = IDX_W'(i);
        end
    end

    always_comb begin
        glyph = GLYPH_BLANK;
        if (disp_err)
            glyph = GLYPH_ERROR;
        else if (scan_idx <= msd_idx)
            glyph = bcd_to_glyph(disp_digit[scan_idx]);
        else if (disp_neg && ({1'b0, scan_idx} == {1'b0, msd_idx} + 1'b1))
            glyph = GLYPH_MINUS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.anodes   <= '1;
            bus.segments <= '1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.anodes   <= ~(DIGITS'(1) << scan_idx);
            bus.segments <= SEGMENTS'(glyph);
            bus.busy     <= (state != IDLE);
            bus.done     <= commit;
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_display.sv
// Drives a 4-digit and a 2-digit instance in lock-step and compares every scanned
// digit against a decimal-arithmetic model of what the display should read.
module tb_seven_segment_scan_display;
    localparam int DW = 8;
    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    int          p4, p2;
    logic [27:0] exp4, exp2;

    seven_segment_scan_display_if #(.DW(DW), .DIGITS(4), .SEGMENTS(7)) bus4 ();
    seven_segment_scan_display_if #(.DW(DW), .DIGITS(2), .SEGMENTS(7)) bus2 ();

    seven_segment_scan_display #(.DW(DW), .DIGITS(4), .SEGMENTS(7), .REFRESH_CYCLES(RC)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    seven_segment_scan_display #(.DW(DW), .DIGITS(2), .SEGMENTS(7), .REFRESH_CYCLES(RC)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] digitGlyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected glyph per display position, worked out in plain decimal arithmetic.
    function automatic logic [27:0] modelGlyphs(input logic [7:0] num, input bit sgn,
                                                input bit err, input int nd);
        int          v, mag, ndig, tmp;
        bit          neg;
        logic [27:0] r;
        logic [6:0]  g;
        v    = sgn ? int'($signed(num)) : int'({24'd0, num});
        neg  = (v < 0);
        mag  = neg ? -v : v;
        ndig = 1;
        tmp  = mag;
        while (tmp >= 10) begin
            tmp = tmp / 10;
            ndig++;
        end
        r   = '1;
        tmp = mag;
        for (int i = 0; i < nd; i++) begin
            if (err || (ndig + (neg ? 1 : 0)) > nd) g = 7'b0001110;
            else if (i < ndig)                      g = digitGlyph(tmp % 10);
            else if (i == ndig && neg)              g = 7'b0111111;
            else                                    g = 7'b1111111;
            tmp = tmp / 10;
            r[i*7 +: 7] = g;
        end
        return r;
    endfunction

    // The scan position is predicted from elapsed cycles since reset release.
    always @(negedge clk) begin
        if (!rst && cyc >= 1) begin
            p4 = ((cyc - 1) / RC) % 4;
            p2 = ((cyc - 1) / RC) % 2;
            checkOutput("anodes4", 32'(bus4.anodes), ~(32'd1 << p4) & 32'hF);
            checkOutput("segments4", 32'(bus4.segments), 32'(exp4[p4*7 +: 7]));
            checkOutput("anodes2", 32'(bus2.anodes), ~(32'd1 << p2) & 32'h3);
            checkOutput("segments2", 32'(bus2.segments), 32'(exp2[p2*7 +: 7]));
        end
    end

    task automatic driveBoth(input bit s, input logic [7:0] num, input bit sgn, input bit err);
        bus4.start = s;  bus4.number = num;  bus4.signed_mode = sgn;  bus4.error = err;
        bus2.start = s;  bus2.number = num;  bus2.signed_mode = sgn;  bus2.error = err;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy4"}, 32'(bus4.busy), 32'd0);
        checkOutput({tag, "_done4"}, 32'(bus4.done), 32'd0);
        checkOutput({tag, "_anodes4"}, 32'(bus4.anodes), 32'hF);
        checkOutput({tag, "_segments4"}, 32'(bus4.segments), 32'h7F);
        checkOutput({tag, "_busy2"}, 32'(bus2.busy), 32'd0);
        checkOutput({tag, "_done2"}, 32'(bus2.done), 32'd0);
        checkOutput({tag, "_anodes2"}, 32'(bus2.anodes), 32'h3);
        checkOutput({tag, "_segments2"}, 32'(bus2.segments), 32'h7F);
    endtask

    task automatic applyStimulus(input logic [7:0] num, input bit sgn, input bit err, input bit midStart);
        logic [27:0] n4, n2;
        n4 = modelGlyphs(num, sgn, err, 4);
        n2 = modelGlyphs(num, sgn, err, 2);
        @(negedge clk);
        driveBoth(1'b1, num, sgn, err);
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        bus2.start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            if (n == 10) begin
                exp4 = n4;
                exp2 = n2;
            end
            @(negedge clk);
            checkOutput("busy4", 32'(bus4.busy), 32'(n <= 9));
            checkOutput("done4", 32'(bus4.done), 32'(n == 9));
            checkOutput("busy2", 32'(bus2.busy), 32'(n <= 9));
            checkOutput("done2", 32'(bus2.done), 32'(n == 9));
            if (midStart && n == 3) driveBoth(1'b1, ~num, ~sgn, ~err);
            if (midStart && n == 4) begin
                bus4.start = 1'b0;
                bus2.start = 1'b0;
            end
        end
    endtask

    task automatic resetMidConversion(input logic [7:0] num);
        @(negedge clk);
        driveBoth(1'b1, num, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        bus2.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 checkReset("rst_conv");
        exp4 = modelGlyphs(8'd0, 1'b0, 1'b0, 4);
        exp2 = modelGlyphs(8'd0, 1'b0, 1'b0, 2);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            checkOutput("post_rst_done4", 32'(bus4.done), 32'd0);
            checkOutput("post_rst_busy4", 32'(bus4.busy), 32'd0);
            checkOutput("post_rst_done2", 32'(bus2.done), 32'd0);
            checkOutput("post_rst_busy2", 32'(bus2.busy), 32'd0);
        end
    endtask

    initial begin
        driveBoth(1'b0, 8'd0, 1'b0, 1'b0);
        exp4 = modelGlyphs(8'd0, 1'b0, 1'b0, 4);
        exp2 = modelGlyphs(8'd0, 1'b0, 1'b0, 2);
        rst  = 1'b0;
        #2 rst = 1'b1;
        #1 checkReset("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        applyStimulus(8'd255, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80,  1'b1, 1'b0, 1'b0);
        applyStimulus(8'hFF,  1'b1, 1'b0, 1'b0);
        applyStimulus(8'd123, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hF7,  1'b1, 1'b0, 1'b0);
        applyStimulus(8'hF6,  1'b1, 1'b0, 1'b0);
        applyStimulus(8'd5,   1'b0, 1'b1, 1'b0);
        applyStimulus(8'd42,  1'b0, 1'b0, 1'b1);
        applyStimulus(8'd0,   1'b1, 1'b0, 1'b0);
        applyStimulus(8'd99,  1'b0, 1'b0, 1'b0);
        applyStimulus(8'd100, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkReset("rst_frame");
        exp4 = modelGlyphs(8'd0, 1'b0, 1'b0, 4);
        exp2 = modelGlyphs(8'd0, 1'b0, 1'b0, 2);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        resetMidConversion(8'd200);
        applyStimulus(8'd77, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
